irq_request_latch: RTL and testbench

//  Front-end stage directly upstream of priority_encoder: converts raw request lines into a latched,

---
 rtl/irq_request_latch_pkg.sv | 13 +
 rtl/priority_encoder.sv | 23 ++
 rtl/irq_request_latch.sv | 81 ++++++++
 tb/tb_irq_request_latch.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/irq_request_latch_pkg.sv
// Shared types for the interrupt request latch front-end.
package irq_request_latch_pkg;

  // Handshake FSM states.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_e;

  localparam int unsigned DEFAULT_M = 4;
  localparam int unsigned DEFAULT_N = 2;

endpackage

// File: rtl/priority_encoder.sv
// Highest-index-wins priority encoder; idx is only meaningful when hit=1.
module priority_encoder #(
  parameter int unsigned m = 4,
  parameter int unsigned n = 2
) (
  input  logic [m-1:0] req_vec,
  output logic [n-1:0] idx,
  output logic         hit
);

  // Ascending scan so the highest set bit is the last to overwrite idx.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < int'(m); i++) begin
      if (req_vec[i]) begin
        idx = n'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_request_latch.sv
// Latches rising edges on request lines into a pending vector and presents
// the highest-priority enabled one to the consumer with a valid/ack handshake.
module irq_request_latch
  import irq_request_latch_pkg::*;
#(
  parameter int unsigned m = DEFAULT_M,
  parameter int unsigned n = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [m-1:0] req,
  input  logic [m-1:0] mask,
  output logic         irq_valid,
  output logic [n-1:0] irq_id,
  input  logic         irq_ack,
  output logic [m-1:0] pending
);

  irq_state_e   state_q;
  irq_state_e   state_d;
  logic [m-1:0] req_d;
  logic [m-1:0] req_rise;
  logic [m-1:0] clr;
  logic [m-1:0] pending_d;
  logic         valid_d;
  logic [n-1:0] id_d;
  logic [n-1:0] enc_idx;
  logic         enc_hit;

  // Only enabled pending lines compete for the consumer.
  priority_encoder #(.m(m), .n(n)) u_enc (
    .req_vec (pending & mask),
    .idx     (enc_idx),
    .hit     (enc_hit)
  );

  assign req_rise = req & ~req_d;

  // Next-state, next-output and pending update; a new edge beats a same-cycle clear.
  always_comb begin
    state_d = state_q;
    valid_d = irq_valid;
    id_d    = irq_id;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (enc_hit) begin
          id_d    = enc_idx;
          valid_d = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (irq_ack) begin
          clr     = m'(1) << irq_id;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
    pending_d = (pending & ~clr) | req_rise;
  end

  // State and output registers; req_d resets high so lines held at release are not events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
      pending   <= '0;
      req_d     <= '1;
    end else begin
      state_q   <= state_d;
      irq_valid <= valid_d;
      irq_id    <= id_d;
      pending   <= pending_d;
      req_d     <= req;
    end
  end

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch with a queue of expected output snapshots.
module tb_irq_request_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] mask;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       v;
    logic [1:0] id;
    logic [3:0] p;
  } exp_t;

  exp_t sb[$];

  irq_request_latch #(.m(4), .n(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mask      (mask),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic v, input logic [1:0] id, input logic [3:0] p);
    exp_t e;
    e.tag = tag; e.v = v; e.id = id; e.p = p;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got %0d entries want >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (irq_valid === e.v) else begin
        errors++;
        $error("FAIL %s irq_valid got %b want %b", e.tag, irq_valid, e.v);
      end
      checks++;
      assert (irq_id === e.id) else begin
        errors++;
        $error("FAIL %s irq_id got %0d want %0d", e.tag, irq_id, e.id);
      end
      checks++;
      assert (pending === e.p) else begin
        errors++;
        $error("FAIL %s pending got %b want %b", e.tag, pending, e.p);
      end
    end
  endtask

  // Expect a snapshot after the next rising edge, sampled 1 time unit later.
  task automatic step(input string tag, input logic v, input logic [1:0] id, input logic [3:0] p);
    push(tag, v, id, p);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    #5000;
    errors++;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 4'b1111; mask = 4'b1111; irq_ack = 1'b0;
    #1;
    // 1: reset state, held lines are not events after release
    push("rst_async", 1'b0, 2'd0, 4'b0000); compare();
    step("rst_clk", 1'b0, 2'd0, 4'b0000);
    rst = 1'b0;
    step("hold_1", 1'b0, 2'd0, 4'b0000);
    step("hold_2", 1'b0, 2'd0, 4'b0000);
    req = 4'b0000;
    step("fall", 1'b0, 2'd0, 4'b0000);

    // 2: single request, latency and ack
    req = 4'b0001;
    step("t2_latch", 1'b0, 2'd0, 4'b0001);
    step("t2_present", 1'b1, 2'd0, 4'b0001);
    irq_ack = 1'b1;
    step("t2_ack", 1'b0, 2'd0, 4'b0000);
    irq_ack = 1'b0; req = 4'b0000;
    step("t2_idle", 1'b0, 2'd0, 4'b0000);

    // 3: two simultaneous edges, highest first then bubble
    req = 4'b1010;
    step("t3_latch", 1'b0, 2'd0, 4'b1010);
    step("t3_pres3", 1'b1, 2'd3, 4'b1010);
    irq_ack = 1'b1;
    step("t3_ack3", 1'b0, 2'd3, 4'b0010);
    irq_ack = 1'b0;
    step("t3_pres1", 1'b1, 2'd1, 4'b0010);
    irq_ack = 1'b1;
    step("t3_ack1", 1'b0, 2'd1, 4'b0000);
    irq_ack = 1'b0; req = 4'b0000;
    step("t3_idle", 1'b0, 2'd1, 4'b0000);

    // 4: masked line latches but does not win until enabled
    mask = 4'b0111; req = 4'b1000;
    step("t4_latch", 1'b0, 2'd1, 4'b1000);
    step("t4_masked", 1'b0, 2'd1, 4'b1000);
    mask = 4'b1111;
    step("t4_unmask", 1'b1, 2'd3, 4'b1000);
    irq_ack = 1'b1;
    step("t4_ack", 1'b0, 2'd3, 4'b0000);
    irq_ack = 1'b0; req = 4'b0000;
    step("t4_idle", 1'b0, 2'd3, 4'b0000);

    // 5: new edge on the presented bit in the ack cycle survives
    req = 4'b0100;
    step("t5_latch", 1'b0, 2'd3, 4'b0100);
    req = 4'b0000;
    step("t5_pres", 1'b1, 2'd2, 4'b0100);
    req = 4'b0100; irq_ack = 1'b1;
    step("t5_ack_set", 1'b0, 2'd2, 4'b0100);
    irq_ack = 1'b0;
    step("t5_repres", 1'b1, 2'd2, 4'b0100);
    irq_ack = 1'b1;
    step("t5_ack", 1'b0, 2'd2, 4'b0000);
    irq_ack = 1'b0; req = 4'b0000;
    step("t5_idle", 1'b0, 2'd2, 4'b0000);

    // 6: reset mid-handshake drops everything without a clock edge
    req = 4'b0010;
    step("t6_latch", 1'b0, 2'd2, 4'b0010);
    step("t6_pres", 1'b1, 2'd1, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    push("t6_async", 1'b0, 2'd0, 4'b0000); compare();
    irq_ack = 1'b1;
    step("t6_rst_ack", 1'b0, 2'd0, 4'b0000);
    rst = 1'b0;
    step("t6_spur_ack", 1'b0, 2'd0, 4'b0000);
    irq_ack = 1'b0;
    step("t6_quiet", 1'b0, 2'd0, 4'b0000);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d entries want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
